imem_port_arbiter: RTL and testbench

//  - Shares the single-port synchronous instruction ROM (32-bit words, word index = byte addr[IDX_W+1:2])

---
 rtl/imem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_imem_port_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// ============================================================================
// Module   : imem_port_arbiter
// Purpose  : Shares a single-port synchronous instruction ROM between the CPU
//            fetch port (F) and the debug/boot port (D). Fixed F priority with
//            starvation relief, or round-robin when IMEM_ARB_RR_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_port_arbiter #(
    parameter int IDX_W      = 5,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_req_i,
    input  logic [31:0]      f_addr_i,
    output logic             f_gnt_o,
    output logic             f_valid_o,
    output logic [DW-1:0]    f_data_o,
    output logic             f_err_o,
    input  logic             d_req_i,
    input  logic [31:0]      d_addr_i,
    output logic             d_gnt_o,
    output logic             d_valid_o,
    output logic [DW-1:0]    d_data_o,
    output logic             d_err_o,
    output logic [IDX_W-1:0] rom_addr_o,
    input  logic [DW-1:0]    rom_q_i
);

    logic             w_f_oor, w_d_oor;
    logic [IDX_W-1:0] w_f_idx, w_d_idx;
    logic             w_f_gnt, w_d_gnt, w_contested;
    logic [IDX_W-1:0] rom_addr_q, rom_addr_d;
    logic             f_valid_q, f_err_q, d_valid_q, d_err_q;
    logic [DW-1:0]    f_hold_q, d_hold_q;
    logic [DW-1:0]    w_f_resp, w_d_resp;
    logic [3:0]       w_unused_addr_lsbs;

    // Byte offset within a word carries no meaning for a word-wide ROM.
    assign w_unused_addr_lsbs = {f_addr_i[1:0], d_addr_i[1:0]};

    assign w_f_oor     = |f_addr_i[31:IDX_W+2];
    assign w_d_oor     = |d_addr_i[31:IDX_W+2];
    assign w_f_idx     = f_addr_i[IDX_W+1:2];
    assign w_d_idx     = d_addr_i[IDX_W+1:2];
    assign w_contested = f_req_i && d_req_i && !rst;

`ifdef IMEM_ARB_RR_EN
    typedef enum logic {PORT_F = 1'b0, PORT_D = 1'b1} port_e;
    port_e rr_ptr_q, rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_contested) begin
            rr_ptr_d = (rr_ptr_q == PORT_F) ? PORT_D : PORT_F;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_ptr_q <= PORT_F;
        else     rr_ptr_q <= rr_ptr_d;
    end

    wire w_d_wins = (rr_ptr_q == PORT_D);
`else
    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);
    logic [3:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (w_d_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (d_req_i && !rst && (starve_cnt_q < c_STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve_cnt_q <= 4'd0;
        else     starve_cnt_q <= starve_cnt_d;
    end

    wire w_d_wins = (starve_cnt_q == c_STARVE_MAX);
`endif

    always_comb begin
        w_f_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (w_contested) begin
            w_d_gnt = w_d_wins;
            w_f_gnt = !w_d_wins;
        end else if (!rst) begin
            w_f_gnt = f_req_i;
            w_d_gnt = d_req_i && !f_req_i;
        end
    end

    // Out-of-range grants leave the ROM index untouched so the macro sees no glitch.
    always_comb begin
        rom_addr_d = rom_addr_q;
        if (w_f_gnt && !w_f_oor) begin
            rom_addr_d = w_f_idx;
        end else if (w_d_gnt && !w_d_oor) begin
            rom_addr_d = w_d_idx;
        end
    end

    assign w_f_resp = f_err_q ? '0 : rom_q_i;
    assign w_d_resp = d_err_q ? '0 : rom_q_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr_q <= '0;
            f_valid_q  <= 1'b0;
            f_err_q    <= 1'b0;
            d_valid_q  <= 1'b0;
            d_err_q    <= 1'b0;
            f_hold_q   <= '0;
            d_hold_q   <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
            f_valid_q  <= w_f_gnt;
            f_err_q    <= w_f_gnt && w_f_oor;
            d_valid_q  <= w_d_gnt;
            d_err_q    <= w_d_gnt && w_d_oor;
            if (f_valid_q) f_hold_q <= w_f_resp;
            if (d_valid_q) d_hold_q <= w_d_resp;
        end
    end

    // ROM data arrives the cycle after the grant, so it is passed straight through then held.
    assign f_gnt_o    = w_f_gnt;
    assign d_gnt_o    = w_d_gnt;
    assign rom_addr_o = rom_addr_d;
    assign f_valid_o  = f_valid_q;
    assign f_err_o    = f_err_q;
    assign f_data_o   = f_valid_q ? w_f_resp : f_hold_q;
    assign d_valid_o  = d_valid_q;
    assign d_err_o    = d_err_q;
    assign d_data_o   = d_valid_q ? w_d_resp : d_hold_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
// ============================================================================
// Module   : tb_imem_port_arbiter
// Purpose  : Directed-vector bench for imem_port_arbiter with a response scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_imem_port_arbiter;

    localparam int IDX_W      = 5;
    localparam int DW         = 32;
    localparam int STARVE_MAX = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             f_req = 1'b0, d_req = 1'b0;
    logic [31:0]      f_addr = '0, d_addr = '0;
    logic             f_gnt_o, f_valid_o, f_err_o;
    logic             d_gnt_o, d_valid_o, d_err_o;
    logic [DW-1:0]    f_data_o, d_data_o, rom_q;
    logic [IDX_W-1:0] rom_addr_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit               fr;
        logic [31:0]      fa;
        bit               dr;
        logic [31:0]      da;
        bit               efg;
        bit               edg;
        logic [IDX_W-1:0] era;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t fq[$];
    exp_t dq[$];
    exp_t fe, de;
    logic [DW-1:0] f_hold = '0, d_hold = '0;

    imem_port_arbiter #(.IDX_W(IDX_W), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .f_req_i    (f_req),
        .f_addr_i   (f_addr),
        .f_gnt_o    (f_gnt_o),
        .f_valid_o  (f_valid_o),
        .f_data_o   (f_data_o),
        .f_err_o    (f_err_o),
        .d_req_i    (d_req),
        .d_addr_i   (d_addr),
        .d_gnt_o    (d_gnt_o),
        .d_valid_o  (d_valid_o),
        .d_data_o   (d_data_o),
        .d_err_o    (d_err_o),
        .rom_addr_o (rom_addr_o),
        .rom_q_i    (rom_q)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_word(input logic [IDX_W-1:0] idx);
        return 32'hC0DE_0000 | (32'(idx) * 32'h0000_0111);
    endfunction

    // Synchronous ROM macro model.
    always @(posedge clk) rom_q <= rom_word(rom_addr_o);

    function automatic exp_t mk(input logic [31:0] addr);
        exp_t e;
        e.err  = |addr[31:IDX_W+2];
        e.data = e.err ? '0 : rom_word(addr[IDX_W+1:2]);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops an expected response whenever a port presents valid.
    always @(negedge clk) begin
        if (rst) begin
            f_hold = '0;
            d_hold = '0;
            chk("f_valid_rst", f_valid_o, 0);
            chk("d_valid_rst", d_valid_o, 0);
        end else begin
            if (f_valid_o) begin
                if (fq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL f_unexpected_valid actual=1 required=0 @%0t", $time);
                end else begin
                    fe = fq.pop_front();
                    chk("f_data", f_data_o, fe.data);
                    chk("f_err", f_err_o, fe.err);
                    f_hold = fe.data;
                end
            end else begin
                chk("f_data_hold", f_data_o, f_hold);
                chk("f_err_idle", f_err_o, 0);
            end
            if (d_valid_o) begin
                if (dq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL d_unexpected_valid actual=1 required=0 @%0t", $time);
                end else begin
                    de = dq.pop_front();
                    chk("d_data", d_data_o, de.data);
                    chk("d_err", d_err_o, de.err);
                    d_hold = de.data;
                end
            end else begin
                chk("d_data_hold", d_data_o, d_hold);
                chk("d_err_idle", d_err_o, 0);
            end
        end
    end

    vec_t vq[$];

    task automatic add(input bit fr, input logic [31:0] fa, input bit dr, input logic [31:0] da,
                       input bit efg, input bit edg, input logic [IDX_W-1:0] era);
        vec_t v;
        v.fr = fr; v.fa = fa; v.dr = dr; v.da = da;
        v.efg = efg; v.edg = edg; v.era = era;
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v, input bit rel);
        @(posedge clk);
        #1;
        if (rel) rst = 1'b0;
        f_req = v.fr; f_addr = v.fa;
        d_req = v.dr; d_addr = v.da;
        #3;
        chk("f_gnt", f_gnt_o, v.efg);
        chk("d_gnt", d_gnt_o, v.edg);
        chk("rom_addr", rom_addr_o, v.era);
        if (v.efg) fq.push_back(mk(v.fa));
        if (v.edg) dq.push_back(mk(v.da));
    endtask

    task automatic reset_check();
        chk("f_gnt_rst", f_gnt_o, 0);
        chk("d_gnt_rst", d_gnt_o, 0);
        chk("rom_addr_rst", rom_addr_o, 0);
        chk("f_data_rst", f_data_o, 0);
        chk("d_data_rst", d_data_o, 0);
        chk("f_err_rst", f_err_o, 0);
        chk("d_err_rst", d_err_o, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with both requests active.
        f_req = 1'b1; f_addr = 32'h08; d_req = 1'b1; d_addr = 32'h14;
        repeat (2) @(posedge clk);
        #4;
        reset_check();

        add(1, 32'h08, 0, 32'h0, 1, 0, 5'd2);
`ifdef IMEM_ARB_RR_EN
        add(1, 32'h20, 1, 32'h14, 1, 0, 5'd8);
        add(1, 32'h24, 1, 32'h14, 0, 1, 5'd5);
        add(1, 32'h28, 1, 32'h14, 1, 0, 5'd10);
        add(1, 32'h2C, 1, 32'h14, 0, 1, 5'd5);
        add(1, 32'h30, 1, 32'h14, 1, 0, 5'd12);
        add(1, 32'h34, 1, 32'h14, 0, 1, 5'd5);
`else
        add(1, 32'h20, 1, 32'h14, 1, 0, 5'd8);
        add(1, 32'h24, 1, 32'h14, 1, 0, 5'd9);
        add(1, 32'h28, 1, 32'h14, 1, 0, 5'd10);
        add(1, 32'h2C, 1, 32'h14, 1, 0, 5'd11);
        add(1, 32'h30, 1, 32'h14, 0, 1, 5'd5);
        add(1, 32'h34, 1, 32'h14, 1, 0, 5'd13);
`endif
        add(1, 32'h3C,        0, 32'h0,  1, 0, 5'd15);
        add(0, 32'h0,         0, 32'h0,  0, 0, 5'd15);
        add(0, 32'h0,         1, 32'h80, 0, 1, 5'd15);
        add(1, 32'h0B,        1, 32'h7C, 1, 0, 5'd2);
        add(0, 32'h0,         1, 32'h7C, 0, 1, 5'd31);
        add(1, 32'hFFFF_FF00, 0, 32'h0,  1, 0, 5'd31);
        add(0, 32'h0,         0, 32'h0,  0, 0, 5'd31);
        add(1, 32'h18,        0, 32'h0,  1, 0, 5'd6);

        // Release reset in the same cycle the first fetch is presented.
        drive(vq[0], 1'b1);
        for (int i = 1; i < vq.size(); i++) drive(vq[i], 1'b0);

        // Reset lands while the last fetch response is in flight.
        @(posedge clk);
        #1;
        rst = 1'b1;
        f_req = 1'b0; d_req = 1'b0;
        fq.delete();
        dq.delete();
        #3;
        reset_check();
        @(posedge clk);
        #1;
        f_req = 1'b1; f_addr = 32'h08;

        vq.delete();
        add(1, 32'h08, 0, 32'h0,  1, 0, 5'd2);
        add(1, 32'h04, 1, 32'h0C, 1, 0, 5'd1);
        add(0, 32'h0,  0, 32'h0,  0, 0, 5'd1);
        add(0, 32'h0,  0, 32'h0,  0, 0, 5'd1);
        drive(vq[0], 1'b1);
        for (int i = 1; i < vq.size(); i++) drive(vq[i], 1'b0);

        @(posedge clk);
        #4;
        chk("f_queue_drained", fq.size(), 0);
        chk("d_queue_drained", dq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
